// File: rtl/pong_game_ctrl.sv
// Pong game controller: tick divider, serve/play/over sequencing, ball motion
// with wall and paddle reflection, paddle motion and scoring. Every output
// comes straight from a register.
module pong_game_ctrl #(
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 30,
  parameter int PADDLE_H    = 8,
  parameter int WIN_SCORE   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [5:0] bx,
  output logic [5:0] by,
  output logic [5:0] p1y,
  output logic [5:0] p2y,
  output logic [2:0] sc1,
  output logic [2:0] sc2,
  output logic [1:0] state,
  output logic [1:0] winner
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SERVE_TICKS + 1);
  localparam logic [5:0] PMAX = 6'(64 - PADDLE_H);

  typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, PLAY = 2'b10, OVER = 2'b11} st_t;

  st_t          st;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic          dxp, dyp;     // 1 = moving +1, 0 = moving -1
  logic          tick;
  logic          hit1, hit2, miss1, miss2;
  logic [5:0]    nbx, nby, np1, np2;
  logic          ndxp, ndyp;

  assign state = st;
  assign tick  = (tcnt == TW'(TICK_DIV - 1));

  // Paddle step: one row per tick, clamped to the playfield; both or neither
  // held means stay put.
  function automatic logic [5:0] pad_next(input logic [5:0] y, input logic up, input logic dn);
    logic [5:0] r;
    r = y;
    if (up && !dn)      r = (y == 6'd0) ? y : y - 6'd1;
    else if (dn && !up) r = (y >= PMAX) ? PMAX : y + 6'd1;
    return r;
  endfunction

  // Hit test uses the paddle positions registered before this tick.
  assign hit1  = ({1'b0, by} >= {1'b0, p1y}) && ({1'b0, by} <= {1'b0, p1y} + 7'(PADDLE_H - 1));
  assign hit2  = ({1'b0, by} >= {1'b0, p2y}) && ({1'b0, by} <= {1'b0, p2y} + 7'(PADDLE_H - 1));
  // miss1: ball left past paddle 2 -> point to player 1; miss2: the reverse.
  assign miss1 = dxp && (bx == 6'd63);
  assign miss2 = !dxp && (bx == 6'd0);
  assign np1   = pad_next(p1y, p1_up, p1_dn);
  assign np2   = pad_next(p2y, p2_up, p2_dn);

  // Next ball position/direction for a non-scoring play tick; axes independent.
  always_comb begin
    nbx  = dxp ? bx + 6'd1 : bx - 6'd1;
    ndxp = dxp;
    if (!dxp && bx == 6'd2 && hit1) begin
      nbx  = 6'd3;
      ndxp = 1'b1;
    end else if (dxp && bx == 6'd61 && hit2) begin
      nbx  = 6'd60;
      ndxp = 1'b0;
    end
    nby  = dyp ? by + 6'd1 : by - 6'd1;
    ndyp = dyp;
    if (!dyp && by == 6'd0) begin
      nby  = 6'd1;
      ndyp = 1'b1;
    end else if (dyp && by == 6'd63) begin
      nby  = 6'd62;
      ndyp = 1'b0;
    end
  end

  // Game state machine, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      tcnt   <= '0;
      scnt   <= '0;
      bx     <= 6'd32;
      by     <= 6'd32;
      p1y    <= 6'd28;
      p2y    <= 6'd28;
      sc1    <= 3'd0;
      sc2    <= 3'd0;
      winner <= 2'b00;
      dxp    <= 1'b1;
      dyp    <= 1'b1;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      case (st)
        IDLE: begin
          if (start) begin
            st   <= SERVE;
            tcnt <= '0;
            scnt <= '0;
          end
        end
        OVER: begin
          if (start) begin
            st     <= SERVE;
            tcnt   <= '0;
            scnt   <= '0;
            sc1    <= 3'd0;
            sc2    <= 3'd0;
            winner <= 2'b00;
            bx     <= 6'd32;
            by     <= 6'd32;
            dxp    <= 1'b1;
            dyp    <= 1'b1;
          end
        end
        SERVE: begin
          if (tick) begin
            p1y <= np1;
            p2y <= np2;
            if (scnt == SW'(SERVE_TICKS - 1)) begin
              st   <= PLAY;
              scnt <= '0;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        PLAY: begin
          if (tick) begin
            p1y <= np1;
            p2y <= np2;
            if (miss1 || miss2) begin
              // Ball holds its position on the scoring tick.
              if (miss1) sc1 <= sc1 + 3'd1;
              else       sc2 <= sc2 + 3'd1;
              if ((miss1 && sc1 == 3'(WIN_SCORE - 1)) || (miss2 && sc2 == 3'(WIN_SCORE - 1))) begin
                st     <= OVER;
                winner <= miss1 ? 2'b01 : 2'b10;
              end else begin
                // Re-serve from centre, heading toward the side of the
                // player who just scored.
                st   <= SERVE;
                scnt <= '0;
                bx   <= 6'd32;
                by   <= 6'd32;
                dxp  <= miss2;
                dyp  <= 1'b1;
              end
            end else begin
              bx  <= nbx;
              by  <= nby;
              dxp <= ndxp;
              dyp <= ndyp;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a driver applies directed and random
// stimulus, a game-level reference model predicts the outputs after each
// edge and queues them; a monitor pops and compares on the falling edge.
module tb_pong_game_ctrl;

  localparam int TD = 2;
  localparam int ST = 4;
  localparam int PH = 8;
  localparam int WS = 5;

  logic       clk = 1'b0;
  logic       rst, start, p1_up, p1_dn, p2_up, p2_dn;
  logic [5:0] bx, by, p1y, p2y;
  logic [2:0] sc1, sc2;
  logic [1:0] state, winner;

  pong_game_ctrl #(.TICK_DIV(TD), .SERVE_TICKS(ST), .PADDLE_H(PH), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .bx(bx), .by(by), .p1y(p1y), .p2y(p2y),
    .sc1(sc1), .sc2(sc2), .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  // Reference game state in plain integers.
  int m_st, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_win, m_dx, m_dy, m_tc, m_sc;
  logic [33:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_reset();
    m_st = 0; m_bx = 32; m_by = 32; m_p1 = 28; m_p2 = 28;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_dx = 1; m_dy = 1; m_tc = 0; m_sc = 0;
  endtask

  function automatic int pad(input int y, input bit up, input bit dn);
    if (up && !dn) return (y > 0) ? y - 1 : 0;
    if (dn && !up) return (y < 64 - PH) ? y + 1 : 64 - PH;
    return y;
  endfunction

  task automatic ball_tick();
    int scorer;
    if ((m_dx < 0 && m_bx == 0) || (m_dx > 0 && m_bx == 63)) begin
      scorer = (m_bx == 63) ? 1 : 2;
      if (scorer == 1) m_s1++; else m_s2++;
      if (m_s1 == WS || m_s2 == WS) begin
        m_st = 3; m_win = scorer;
      end else begin
        m_st = 1; m_sc = 0; m_bx = 32; m_by = 32; m_dy = 1;
        m_dx = (scorer == 1) ? -1 : 1;
      end
      return;
    end
    if ((m_dx < 0 && m_bx == 2 && m_by >= m_p1 && m_by < m_p1 + PH) ||
        (m_dx > 0 && m_bx == 61 && m_by >= m_p2 && m_by < m_p2 + PH))
      m_dx = -m_dx;
    m_bx += m_dx;
    if (m_by + m_dy < 0 || m_by + m_dy > 63) m_dy = -m_dy;
    m_by += m_dy;
  endtask

  task automatic model_step(input bit r, input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    bit tk;
    if (r) begin model_reset(); return; end
    tk = (m_tc == TD - 1);
    m_tc = (m_tc + 1) % TD;
    if (m_st == 0 || m_st == 3) begin
      if (s) begin
        if (m_st == 3) begin
          m_s1 = 0; m_s2 = 0; m_win = 0; m_bx = 32; m_by = 32; m_dx = 1; m_dy = 1;
        end
        m_st = 1; m_tc = 0; m_sc = 0;
      end
      return;
    end
    if (!tk) return;
    if (m_st == 2) ball_tick();
    else begin
      m_sc++;
      if (m_sc == ST) begin m_st = 2; m_sc = 0; end
    end
    m_p1 = pad(m_p1, u1, d1);
    m_p2 = pad(m_p2, u2, d2);
  endtask

  function automatic logic [33:0] model_pack();
    return {2'(m_st), 2'(m_win), 3'(m_s1), 3'(m_s2), 6'(m_bx), 6'(m_by), 6'(m_p1), 6'(m_p2)};
  endfunction

  // One clock: apply inputs, let the edge happen, queue the prediction.
  task automatic cyc(input bit r, input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    rst = r; start = s; p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    @(posedge clk);
    model_step(r, s, u1, d1, u2, d2);
    exp_q.push_back(model_pack());
    #1;
  endtask

  // Monitor: every output is registered, so one prediction per edge.
  always @(negedge clk) begin
    logic [33:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, winner, sc1, sc2, bx, by, p1y, p2y};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got st=%0d win=%0d sc=%0d/%0d ball=(%0d,%0d) pad=%0d/%0d, want st=%0d win=%0d sc=%0d/%0d ball=(%0d,%0d) pad=%0d/%0d",
                 $time, a[33:32], a[31:30], a[29:27], a[26:24], a[23:18], a[17:12], a[11:6], a[5:0],
                 e[33:32], e[31:30], e[29:27], e[26:24], e[23:18], e[17:12], e[11:6], e[5:0]);
      end
    end
  end

  initial begin
    bit s, u1, d1, u2, d2, track;
    int tgt;
    model_reset();
    // Reset, idle hold, then start into serve.
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 0, 0, 0);
    // Paddle 1 driven to the top clamp, then both buttons together.
    repeat (90) cyc(0, 0, 1, 0, 0, 0);
    repeat (20) cyc(0, 0, 1, 1, 1, 1);
    repeat (60) cyc(0, 0, 0, 1, 0, 1);
    // Reset while playing, with start asserted alongside.
    cyc(1, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // Randomised play: alternates between random paddles and ball tracking
    // so that both rallies (paddle and corner hits) and misses occur.
    track = 1'b0;
    u1 = 0; d1 = 0; u2 = 0; d2 = 0;
    for (int i = 0; i < 20000; i++) begin
      if (i % 400 == 0) track = $urandom_range(0, 2) != 0;
      if (track) begin
        tgt = m_by - int'($urandom_range(0, PH - 1));
        u1 = m_p1 > tgt; d1 = m_p1 < tgt;
        tgt = m_by - int'($urandom_range(0, PH - 1));
        u2 = m_p2 > tgt; d2 = m_p2 < tgt;
        if ($urandom_range(0, 9) == 0) begin u1 = 0; d1 = 0; end
      end else if ($urandom_range(0, 7) == 0) begin
        {u1, d1, u2, d2} = 4'($urandom_range(0, 15));
      end
      s = $urandom_range(0, 39) == 0;
      cyc($urandom_range(0, 2999) == 0, s, u1, d1, u2, d2);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
